// File: rtl/mfc_operand_loader.sv
// Bit-serial operand loader feeding the multi-function comparator.
// Shifts two operands in LSB first, holds them through a settle window, then flags ready.
module mfc_operand_loader #(
   parameter int WIDTH  = 16,
   parameter int SETTLE = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sin_a,
   input  logic             sin_b,
   input  logic             ack,
   output logic [WIDTH-1:0] A,
   output logic [WIDTH-1:0] B,
   output logic             busy,
   output logic             ready
);

   localparam int BW = $clog2(WIDTH) + 1;
   localparam int SW = $clog2(SETTLE + 1) + 1;
   localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
   // Last settle count before HOLD; unused when SETTLE is zero.
   localparam logic [SW-1:0] SET_LAST = SW'((SETTLE > 0) ? (SETTLE - 1) : 0);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SHIFT  = 2'd1,
      S_SETTLE = 2'd2,
      S_HOLD   = 2'd3
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [SW-1:0]    set_cnt_q, set_cnt_d;
   logic             busy_q, busy_d;
   logic             ready_q, ready_d;

   // Next-state, operand shift and counter logic.
   always_comb begin
      state_d   = state_q;
      a_d       = a_q;
      b_d       = b_q;
      bit_cnt_d = bit_cnt_q;
      set_cnt_d = set_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d   = S_SHIFT;
               bit_cnt_d = {BW{1'b0}};
            end else begin
               state_d   = S_IDLE;
            end
         end
         S_SHIFT: begin
            a_d       = {sin_a, a_q[WIDTH-1:1]};
            b_d       = {sin_b, b_q[WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + {{(BW-1){1'b0}}, 1'b1};
            if (bit_cnt_q == BIT_LAST) begin
               set_cnt_d = {SW{1'b0}};
               state_d   = (SETTLE > 0) ? S_SETTLE : S_HOLD;
            end else begin
               state_d   = S_SHIFT;
            end
         end
         S_SETTLE: begin
            set_cnt_d = set_cnt_q + {{(SW-1){1'b0}}, 1'b1};
            if (set_cnt_q == SET_LAST) begin
               state_d = S_HOLD;
            end else begin
               state_d = S_SETTLE;
            end
         end
         S_HOLD: begin
            // start alongside ack is dropped: a fresh start is needed in IDLE.
            if (ack) begin
               state_d = S_IDLE;
            end else begin
               state_d = S_HOLD;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d  = (state_d == S_SHIFT) || (state_d == S_SETTLE);
      ready_d = (state_d == S_HOLD);
   end

   // State and registered outputs, asynchronously cleared.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         a_q       <= {WIDTH{1'b0}};
         b_q       <= {WIDTH{1'b0}};
         bit_cnt_q <= {BW{1'b0}};
         set_cnt_q <= {SW{1'b0}};
         busy_q    <= 1'b0;
         ready_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         a_q       <= a_d;
         b_q       <= b_d;
         bit_cnt_q <= bit_cnt_d;
         set_cnt_q <= set_cnt_d;
         busy_q    <= busy_d;
         ready_q   <= ready_d;
      end
   end

   assign A     = a_q;
   assign B     = b_q;
   assign busy  = busy_q;
   assign ready = ready_q;

endmodule

// File: tb/tb_mfc_operand_loader.sv
// Scoreboard bench: one loader with the default settle window and one with SETTLE=0,
// driven by shared directed vectors; monitors check each ready rise against queued expectations.
module tb_mfc_operand_loader;

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      int          e;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        sin_a = 1'b0;
   logic        sin_b = 1'b0;
   logic        ack = 1'b0;
   logic [15:0] A0, B0, A1, B1;
   logic        busy0, ready0, busy1, ready1;
   logic        pr0 = 1'b0;
   logic        pr1 = 1'b0;
   int          edge_n = 0;
   int          checks = 0;
   int          errors = 0;
   exp_t        q0[$];
   exp_t        q1[$];

   mfc_operand_loader #(.WIDTH(16), .SETTLE(8)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .sin_a(sin_a), .sin_b(sin_b), .ack(ack),
      .A(A0), .B(B0), .busy(busy0), .ready(ready0)
   );

   mfc_operand_loader #(.WIDTH(16), .SETTLE(0)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .sin_a(sin_a), .sin_b(sin_b), .ack(ack),
      .A(A1), .B(B1), .busy(busy1), .ready(ready1)
   );

   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Monitor for the SETTLE=8 instance.
   always @(negedge clk) begin
      if (ready0 && !pr0) begin
         if (q0.size() == 0) begin
            chk("d0_unexpected_ready", 64'd1, 64'd0);
         end else begin
            chk("d0_ready_edge", 64'(edge_n), 64'(q0[0].e));
            chk("d0_operands", {32'd0, A0, B0}, {32'd0, q0[0].a, q0[0].b});
            void'(q0.pop_front());
         end
      end else if (q0.size() > 0 && edge_n > q0[0].e + 2) begin
         chk("d0_ready_timeout", 64'(edge_n), 64'(q0[0].e));
         void'(q0.pop_front());
      end
      pr0 <= ready0;
   end

   // Monitor for the SETTLE=0 instance.
   always @(negedge clk) begin
      if (ready1 && !pr1) begin
         if (q1.size() == 0) begin
            chk("d1_unexpected_ready", 64'd1, 64'd0);
         end else begin
            chk("d1_ready_edge", 64'(edge_n), 64'(q1[0].e));
            chk("d1_operands", {32'd0, A1, B1}, {32'd0, q1[0].a, q1[0].b});
            void'(q1.pop_front());
         end
      end else if (q1.size() > 0 && edge_n > q1[0].e + 2) begin
         chk("d1_ready_timeout", 64'(edge_n), 64'(q1[0].e));
         void'(q1.pop_front());
      end
      pr1 <= ready1;
   end

   // One full load; t counts edges from the start edge E0 up to the ack edge.
   task automatic load(input logic [15:0] a, input logic [15:0] b, input bit ign,
                       input int ack_off, input bit ackws);
      exp_t x;
      x.a = a;
      x.b = b;
      x.e = edge_n + 1 + 24;
      q0.push_back(x);
      x.e = edge_n + 1 + 16;
      q1.push_back(x);
      for (int t = 0; t <= ack_off; t++) begin
         start = (t == 0) || (ign && (t == 5 || t == 20)) || (ackws && t == ack_off);
         ack   = (t == ack_off) || (ign && t == 10);
         if (t >= 1 && t <= 16) begin
            sin_a = a[t-1];
            sin_b = b[t-1];
         end else begin
            sin_a = ($urandom_range(0, 1) == 1);
            sin_b = ($urandom_range(0, 1) == 1);
         end
         @(posedge clk);
         @(negedge clk);
         if (t == 0) chk("busy_after_start", {63'd0, busy0}, 64'd1);
         if (t == 16) begin
            chk("d0_busy_in_settle", {62'd0, busy0, ready0}, 64'd2);
            chk("d1_ready_no_settle", {62'd0, busy1, ready1}, 64'd1);
         end
         if (t >= 16) begin
            chk("d0_stable", {32'd0, A0, B0}, {32'd0, a, b});
            chk("d1_stable", {32'd0, A1, B1}, {32'd0, a, b});
         end
         if (t == ack_off) begin
            chk("ready_after_ack", {60'd0, busy0, ready0, busy1, ready1}, 64'd0);
         end
         start = 1'b0;
         ack   = 1'b0;
      end
   endtask

   initial begin
      #1 rst = 1'b0;
      #1;
      chk("por_outputs", {A0, B0, A1, B1}, 64'd0);
      chk("por_flags", {60'd0, busy0, ready0, busy1, ready1}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);

      // Equal operands.
      load(16'h53DB, 16'h53DB, 1'b0, 26, 1'b0);
      // Distinct operands with ack exactly at E30.
      load(16'h8001, 16'h7FFF, 1'b0, 30, 1'b0);
      chk("idle_keeps_operands", {A0, B0, A1, B1}, {16'h8001, 16'h7FFF, 16'h8001, 16'h7FFF});
      // Ignored start/ack pulses during SHIFT and SETTLE.
      load(16'h1234, 16'hFEDC, 1'b1, 26, 1'b0);

      // Asynchronous reset mid-SHIFT.
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         sin_a = 1'b1;
         sin_b = 1'b1;
         @(posedge clk);
         @(negedge clk);
      end
      chk("busy_before_reset", {63'd0, busy0}, 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("reset_operands", {A0, B0, A1, B1}, 64'd0);
      chk("reset_flags", {60'd0, busy0, ready0, busy1, ready1}, 64'd0);
      @(negedge clk);
      rst = 1'b1;
      sin_a = 1'b0;
      sin_b = 1'b0;
      load(16'h00F1, 16'h0F10, 1'b0, 25, 1'b0);

      // start together with ack in HOLD, then a fresh start on the very next edge.
      load(16'hA5C3, 16'h3C5A, 1'b0, 25, 1'b1);
      load(16'hFFFF, 16'h0000, 1'b0, 25, 1'b0);

      repeat (4) @(negedge clk);
      chk("q0_drained", 64'(q0.size()), 64'd0);
      chk("q1_drained", 64'(q1.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1);
   end

endmodule
